ysyx_22040750_clint: RTL and testbench



---
 rtl/ysyx_22040750_clint_pkg.sv | 31 +++
 rtl/ysyx_22040750_clint_prescaler.sv | 28 ++
 rtl/ysyx_22040750_clint.sv | 143 ++++++++++++++
 tb/tb_ysyx_22040750_clint.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040750_clint_pkg.sv
// Shared constants, state encoding and the byte-merge helper for the CLINT.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ysyx_22040750_clint_pkg;

   // Register offsets inside the 64 KiB CLINT window
   localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
   localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
   localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

   // mtimecmp powers up at the maximum so no timer interrupt fires before software arms it
   localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } clint_state_t;

   // Replace the bytes of old_val selected by strb with the matching bytes of new_val
   function automatic logic [63:0] clint_merge(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  strb);
      logic [63:0] res;
      res = old_val;
      for (int b = 0; b < 8; b++) begin
         if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/ysyx_22040750_clint_prescaler.sv
// Tick generator: counts 0..TICK_DIV-1 and pulses tick on the last count.
// Latency: tick is combinational from the count register.
// Backpressure: none, free running.
module ysyx_22040750_clint_prescaler #(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   output logic        tick,
   output logic [15:0] count
);

   localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

   assign tick = (count == LAST);

   // Wrap to zero on the tick cycle, otherwise count up
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + 16'd1;
      end
   end

endmodule

// File: rtl/ysyx_22040750_clint.sv
// Core-local interruptor: mtime/mtimecmp (and msip when CLINT_MSIP_EN) behind a single-outstanding MMIO port.
// Latency: response valid 1 cycle after acceptance; O_mtip lags register changes by 1 cycle.
// Backpressure: O_req_ready drops while a response is held; rdata/err stay stable until I_resp_ready.
module ysyx_22040750_clint
   import ysyx_22040750_clint_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int unsigned TICK_DIV  = 1
) (
   input  logic        I_sys_clk,
   input  logic        I_rst,
   input  logic        I_req_valid,
   output logic        O_req_ready,
   input  logic        I_req_wen,
   input  logic [31:0] I_req_addr,
   input  logic [63:0] I_req_wdata,
   input  logic [7:0]  I_req_wstrb,
   output logic        O_resp_valid,
   input  logic        I_resp_ready,
   output logic [63:0] O_resp_rdata,
   output logic        O_resp_err,
   output logic        O_mtip,
   output logic        O_msip
);

   clint_state_t state, state_nxt;

   logic [63:0] mtime_q, mtimecmp_q, mtime_inc;
   logic        msip_q;
   logic        tick;
   logic [15:0] unused_presc_count;

   logic        accept, hit, aligned;
   logic        sel_mtime, sel_mtimecmp, sel_msip, dec_err;
   logic [15:0] off;
   logic [63:0] rd_val;

   ysyx_22040750_clint_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk   (I_sys_clk),
      .rst   (I_rst),
      .tick  (tick),
      .count (unused_presc_count)
   );

   // ---------------- decode ----------------
   assign accept       = I_req_valid & (state == ST_IDLE);
   assign hit          = (I_req_addr[31:16] == BASE_ADDR[31:16]);
   assign off          = I_req_addr[15:0];
   assign aligned      = (I_req_addr[2:0] == 3'b000);
   assign sel_mtime    = hit & aligned & (off == CLINT_MTIME_OFF);
   assign sel_mtimecmp = hit & aligned & (off == CLINT_MTIMECMP_OFF);
`ifdef CLINT_MSIP_EN
   assign sel_msip     = hit & aligned & (off == CLINT_MSIP_OFF);
`else
   assign sel_msip     = 1'b0;
`endif
   assign dec_err      = ~(sel_mtime | sel_mtimecmp | sel_msip);

   // mtime value after this cycle's tick, before any write is merged in
   assign mtime_inc = tick ? mtime_q + 64'd1 : mtime_q;

   // Read mux: pre-tick register values; writes and errors return zero
   always_comb begin
      rd_val = '0;
      if (!I_req_wen) begin
         if (sel_mtime)         rd_val = mtime_q;
         else if (sel_mtimecmp) rd_val = mtimecmp_q;
         else if (sel_msip)     rd_val = {63'b0, msip_q};
      end
   end

   // ---------------- FSM ----------------
   // State register
   always_ff @(posedge I_sys_clk) begin
      if (I_rst) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next state: one access in flight, released by the response handshake
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (I_req_valid)  state_nxt = ST_RESP;
         ST_RESP: if (I_resp_ready) state_nxt = ST_IDLE;
         default:                   state_nxt = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      O_req_ready  = 1'b0;
      O_resp_valid = 1'b0;
      case (state)
         ST_IDLE: O_req_ready  = 1'b1;
         ST_RESP: O_resp_valid = 1'b1;
         default: ;
      endcase
   end

   // Response payload latched on acceptance and held through stalls
   always_ff @(posedge I_sys_clk) begin
      if (I_rst) begin
         O_resp_rdata <= '0;
         O_resp_err   <= 1'b0;
      end else if (accept) begin
         O_resp_rdata <= rd_val;
         O_resp_err   <= dec_err;
      end
   end

   // ---------------- registers ----------------
   // mtime: ticks every prescaler wrap; written bytes override the incremented value
   always_ff @(posedge I_sys_clk) begin
      if (I_rst)                              mtime_q <= '0;
      else if (accept && I_req_wen && sel_mtime) mtime_q <= clint_merge(mtime_inc, I_req_wdata, I_req_wstrb);
      else                                    mtime_q <= mtime_inc;
   end

   // mtimecmp: byte-merged software writes only
   always_ff @(posedge I_sys_clk) begin
      if (I_rst)                                    mtimecmp_q <= CLINT_MTIMECMP_RST;
      else if (accept && I_req_wen && sel_mtimecmp) mtimecmp_q <= clint_merge(mtimecmp_q, I_req_wdata, I_req_wstrb);
   end

`ifdef CLINT_MSIP_EN
   // msip: single bit written through byte lane 0
   always_ff @(posedge I_sys_clk) begin
      if (I_rst)                                              msip_q <= 1'b0;
      else if (accept && I_req_wen && sel_msip && I_req_wstrb[0]) msip_q <= I_req_wdata[0];
   end
`else
   assign msip_q = 1'b0;
`endif

   assign O_msip = msip_q;

   // Timer pending compares the current register values, so it trails them by one cycle
   always_ff @(posedge I_sys_clk) begin
      if (I_rst) O_mtip <= 1'b0;
      else       O_mtip <= (mtime_q >= mtimecmp_q);
   end

endmodule

// File: tb/tb_ysyx_22040750_clint.sv
// Bench for the CLINT: two instances (TICK_DIV 1 and 4) against a behavioural model.
// Latency: n/a.
// Backpressure: response stalls are randomised.
module tb_ysyx_22040750_clint;

   localparam logic [31:0] BASE  = 32'h0200_0000;
   localparam logic [31:0] A_CMP  = BASE + 32'h4000;
   localparam logic [31:0] A_TIME = BASE + 32'hBFF8;
   localparam int K_ERR = 0, K_CMP = 1, K_TIME = 2, K_MSIP = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid  [2];
   logic        req_ready  [2];
   logic        req_wen    [2];
   logic [31:0] req_addr   [2];
   logic [63:0] req_wdata  [2];
   logic [7:0]  req_wstrb  [2];
   logic        resp_valid [2];
   logic        resp_ready [2];
   logic [63:0] resp_rdata [2];
   logic        resp_err   [2];
   logic        mtip       [2];
   logic        msip       [2];

   ysyx_22040750_clint #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut_d1 (
      .I_sys_clk(clk), .I_rst(rst),
      .I_req_valid(req_valid[0]), .O_req_ready(req_ready[0]), .I_req_wen(req_wen[0]),
      .I_req_addr(req_addr[0]), .I_req_wdata(req_wdata[0]), .I_req_wstrb(req_wstrb[0]),
      .O_resp_valid(resp_valid[0]), .I_resp_ready(resp_ready[0]),
      .O_resp_rdata(resp_rdata[0]), .O_resp_err(resp_err[0]),
      .O_mtip(mtip[0]), .O_msip(msip[0])
   );

   ysyx_22040750_clint #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut_d4 (
      .I_sys_clk(clk), .I_rst(rst),
      .I_req_valid(req_valid[1]), .O_req_ready(req_ready[1]), .I_req_wen(req_wen[1]),
      .I_req_addr(req_addr[1]), .I_req_wdata(req_wdata[1]), .I_req_wstrb(req_wstrb[1]),
      .O_resp_valid(resp_valid[1]), .I_resp_ready(resp_ready[1]),
      .O_resp_rdata(resp_rdata[1]), .O_resp_err(resp_err[1]),
      .O_mtip(mtip[1]), .O_msip(msip[1])
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [63:0] m_time [2];
   logic [63:0] m_cmp  [2];
   logic        m_mtip [2];
   logic        m_msip [2];
   int unsigned cyc    [2];
   logic [64:0] expq0[$];
   logic [64:0] expq1[$];

   function automatic int tdiv(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   function automatic logic [63:0] tick_now(input int i);
      return ((cyc[i] % tdiv(i)) == tdiv(i) - 1) ? 64'd1 : 64'd0;
   endfunction

   function automatic int addr_kind(input logic [31:0] a);
      if (a[31:16] != BASE[31:16] || a[2:0] != 3'b000) return K_ERR;
      case (a[15:0])
         16'h4000: return K_CMP;
         16'hBFF8: return K_TIME;
`ifdef CLINT_MSIP_EN
         16'h0000: return K_MSIP;
`endif
         default:  return K_ERR;
      endcase
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] s);
      logic [63:0] mask;
      for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{s[b]}};
      return (o & ~mask) | (n & mask);
   endfunction

   // expected {err, rdata} for the request currently presented on instance i
   function automatic logic [64:0] model_resp(input int i);
      int k;
      k = addr_kind(req_addr[i]);
      if (k == K_ERR) return {1'b1, 64'd0};
      if (req_wen[i]) return {1'b0, 64'd0};
      case (k)
         K_TIME:  return {1'b0, m_time[i]};
         K_CMP:   return {1'b0, m_cmp[i]};
         default: return {1'b0, 63'd0, m_msip[i]};
      endcase
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_time[i] <= '0;
            m_cmp[i]  <= '1;
            m_mtip[i] <= 1'b0;
            m_msip[i] <= 1'b0;
            cyc[i]    <= 0;
            if (i == 0) expq0.delete(); else expq1.delete();
         end else begin
            m_mtip[i] <= (m_time[i] >= m_cmp[i]);
            cyc[i]    <= cyc[i] + 1;
            m_time[i] <= m_time[i] + tick_now(i);
            if (req_valid[i] && req_ready[i]) begin
               if (i == 0) expq0.push_back(model_resp(i)); else expq1.push_back(model_resp(i));
               if (req_wen[i] && addr_kind(req_addr[i]) == K_TIME)
                  m_time[i] <= merge(m_time[i] + tick_now(i), req_wdata[i], req_wstrb[i]);
               if (req_wen[i] && addr_kind(req_addr[i]) == K_CMP)
                  m_cmp[i] <= merge(m_cmp[i], req_wdata[i], req_wstrb[i]);
               if (req_wen[i] && addr_kind(req_addr[i]) == K_MSIP && req_wstrb[i][0])
                  m_msip[i] <= req_wdata[i][0];
            end
         end
      end
   end

   // timer/software pending compared every cycle, away from the active edge
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk("mtip", 64'(mtip[i]), 64'(m_mtip[i]));
         chk("msip", 64'(msip[i]), 64'(m_msip[i]));
      end
   end

   // ---------------- transaction driver ----------------
   task automatic xact(input int i, input logic wen, input logic [31:0] addr,
                       input logic [63:0] wdata, input logic [7:0] wstrb, input int stall,
                       output logic [63:0] rdata, output logic err);
      logic [64:0] e;
      int n;
      @(negedge clk);
      req_valid[i] = 1'b1;
      req_wen[i]   = wen;
      req_addr[i]  = addr;
      req_wdata[i] = wdata;
      req_wstrb[i] = wstrb;
      n = 0;
      while (!req_ready[i] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready[i]) chk("req_ready_timeout", 64'd0, 64'd1);
      @(negedge clk);
      req_valid[i] = 1'b0;
      chk("resp_valid", 64'(resp_valid[i]), 64'd1);
      chk("req_ready_busy", 64'(req_ready[i]), 64'd0);
      e = '0;
      if (i == 0 && expq0.size() > 0) e = expq0.pop_front();
      else if (i == 1 && expq1.size() > 0) e = expq1.pop_front();
      else chk("exp_queue_empty", 64'd0, 64'd1);
      chk("rdata", resp_rdata[i], e[63:0]);
      chk("err", 64'(resp_err[i]), 64'(e[64]));
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk("stall_valid", 64'(resp_valid[i]), 64'd1);
         chk("stall_rdata", resp_rdata[i], e[63:0]);
         chk("stall_err", 64'(resp_err[i]), 64'(e[64]));
         chk("stall_ready", 64'(req_ready[i]), 64'd0);
      end
      rdata = resp_rdata[i];
      err   = resp_err[i];
      resp_ready[i] = 1'b1;
      @(negedge clk);
      resp_ready[i] = 1'b0;
      chk("resp_done", 64'(resp_valid[i]), 64'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [63:0] r, r2, wd;
      logic        er;
      logic [31:0] a;
      logic [7:0]  st;
      int          i, op, n;

      for (int k = 0; k < 2; k++) begin
         req_valid[k] = 1'b0; req_wen[k] = 1'b0; req_addr[k] = '0;
         req_wdata[k] = '0;  req_wstrb[k] = '0; resp_ready[k] = 1'b0;
      end

      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rst_req_ready",  64'(req_ready[k]),  64'd1);
         chk("rst_resp_valid", 64'(resp_valid[k]), 64'd0);
         chk("rst_rdata",      resp_rdata[k],      64'd0);
         chk("rst_err",        64'(resp_err[k]),   64'd0);
         chk("rst_mtip",       64'(mtip[k]),       64'd0);
         chk("rst_msip",       64'(msip[k]),       64'd0);
      end
      rst = 1'b0;

      // mtime read 10 cycles after reset release
      repeat (9) @(negedge clk);
      xact(0, 1'b0, A_TIME, 64'd0, 8'h00, 0, r, er);
      chk("mtime_at_10", r, 64'd10);
      chk("mtime_at_10_err", 64'(er), 64'd0);

      // mtimecmp = 50: mtip rises once mtime reaches 50, falls when cmp is raised
      xact(0, 1'b1, A_CMP, 64'd50, 8'hFF, 0, r, er);
      n = 0;
      while (!mtip[0] && n < 100) begin @(negedge clk); n++; end
      chk("mtip_rise", 64'(mtip[0]), 64'd1);
      xact(0, 1'b1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, r, er);
      repeat (2) @(negedge clk);
      chk("mtip_fall", 64'(mtip[0]), 64'd0);

      // TICK_DIV = 4: acceptances 40 cycles apart differ by exactly 10
      xact(1, 1'b0, A_TIME, 64'd0, 8'h00, 0, r, er);
      repeat (37) @(negedge clk);
      xact(1, 1'b0, A_TIME, 64'd0, 8'h00, 0, r2, er);
      chk("tdiv4_delta", r2 - r, 64'd10);

      // wrap of mtime with mtimecmp = 0
      xact(0, 1'b1, A_CMP, 64'd0, 8'hFF, 0, r, er);
      xact(0, 1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, r, er);
      xact(0, 1'b0, A_TIME, 64'd0, 8'h00, 0, r, er);
      chk("wrap_small", 64'(r < 64'd8), 64'd1);
      chk("wrap_mtip", 64'(mtip[0]), 64'd1);

      // partial write to an all-ones mtimecmp
      xact(0, 1'b1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, r, er);
      xact(0, 1'b1, A_CMP, 64'h1111_2222_3333_4444, 8'h0F, 0, r, er);
      xact(0, 1'b0, A_CMP, 64'd0, 8'h00, 0, r, er);
      chk("partial_cmp", r, 64'hFFFF_FFFF_3333_4444);

      // 5-cycle response stall
      xact(0, 1'b0, A_TIME, 64'd0, 8'h00, 5, r, er);

      // error accesses leave state untouched
      xact(0, 1'b0, BASE + 32'h0008, 64'd0, 8'h00, 0, r, er);
      chk("err_0008", 64'(er), 64'd1);
      xact(0, 1'b1, BASE + 32'h4004, 64'd0, 8'hFF, 0, r, er);
      chk("err_4004", 64'(er), 64'd1);
      xact(0, 1'b1, 32'h0300_4000, 64'd0, 8'hFF, 0, r, er);
      xact(0, 1'b0, A_CMP, 64'd0, 8'h00, 0, r, er);
      chk("cmp_after_err", r, 64'hFFFF_FFFF_3333_4444);
      xact(0, 1'b1, BASE, 64'd1, 8'hFF, 0, r, er);
      xact(0, 1'b0, BASE, 64'd0, 8'h00, 0, r, er);

      // reset while a response is pending drops it
      @(negedge clk);
      req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = A_TIME;
      @(negedge clk);
      req_valid[0] = 1'b0;
      chk("pre_rst_valid", 64'(resp_valid[0]), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_drop_valid", 64'(resp_valid[0]), 64'd0);
      chk("rst_drop_rdata", resp_rdata[0], 64'd0);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("no_resp_after_rst", 64'(resp_valid[0]), 64'd0);
      end

      // randomised traffic against the model
      for (int it = 0; it < 150; it++) begin
         i  = $urandom_range(0, 1);
         op = $urandom_range(0, 6);
         wd = {$urandom, $urandom};
         st = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
         case (op)
            0: xact(i, 1'b0, A_TIME, wd, st, $urandom_range(0, 2), r, er);
            1: xact(i, 1'b0, A_CMP,  wd, st, $urandom_range(0, 2), r, er);
            2: xact(i, 1'b1, A_CMP,  m_time[i] + 64'($urandom_range(0, 30)), st, $urandom_range(0, 2), r, er);
            3: xact(i, 1'b1, A_TIME, ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 200)) : wd,
                    st, $urandom_range(0, 2), r, er);
            4: begin
                  a = A_CMP + 32'($urandom_range(1, 7));
                  xact(i, 1'($urandom), a, wd, st, $urandom_range(0, 2), r, er);
               end
            5: begin
                  a = {BASE[31:16], 13'($urandom), 3'b000};
                  xact(i, 1'($urandom), a, wd, st, $urandom_range(0, 2), r, er);
               end
            default: begin
                  a = {16'h1000 + 16'($urandom_range(0, 255)), 16'h4000};
                  xact(i, 1'($urandom), a, wd, st, $urandom_range(0, 2), r, er);
               end
         endcase
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
